argmax_sequencer: RTL

//  Sequential classifier back-end: accepts the HEIGHT signed scores of the final

---
 rtl/argmax_sequencer.sv | 134 +++++++++++++
 1 files changed

// File: rtl/argmax_sequencer.sv
// argmax_sequencer: classifier back-end. Takes HEIGHT signed scores, one per accepted beat
// on a valid/ready stream, keeps a running maximum, and then presents the index of the
// winning score on a valid/ready output handshake.
//
// Ports:
//   clk, reset       rising-edge clock; asynchronous active-low reset
//   clear            synchronous frame abort (active-high); drops any score offered that cycle
//   in_valid/ready   input score handshake; in_data is the signed score, in_last marks frame end
//   out_valid/ready  result handshake
//   predict_num      index of the maximum score (all-ones after reset)
//   frame_err        in_last did not line up with the fixed frame length in this frame
//   max_score        winning score (only with ARGMAX_SCORE_EN defined)
//
// Build option: define ARGMAX_SCORE_EN to expose max_score.

module argmax_sequencer #(
  parameter int unsigned BITS   = 24,
  parameter int unsigned HEIGHT = 10,
  parameter int unsigned IDX_W  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BITS-1:0]  in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] predict_num,
  output logic             frame_err
`ifdef ARGMAX_SCORE_EN
  ,
  output logic [BITS-1:0]  max_score
`endif
);

  typedef enum logic [0:0] {StCollect, StHold} state_e;

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(HEIGHT - 1);

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic signed [BITS-1:0]  max_q, max_d;
  logic [IDX_W-1:0]        best_q, best_d;
  logic                    err_q, err_d;
  logic [IDX_W-1:0]        predict_q, predict_d;
  logic                    frame_err_q, frame_err_d;
  logic [BITS-1:0]         score_q, score_d;
  logic                    is_last_pos;

  assign in_ready    = (state_q == StCollect);
  assign out_valid   = (state_q == StHold);
  assign predict_num = predict_q;
  assign frame_err   = frame_err_q;
  assign is_last_pos = (idx_q == LastIdx);

`ifdef ARGMAX_SCORE_EN
  assign max_score = score_q;
`endif

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    max_d       = max_q;
    best_d      = best_q;
    err_d       = err_q;
    predict_d   = predict_q;
    frame_err_d = frame_err_q;
    score_d     = score_q;

    if (clear) begin
      // Abort the frame; the last published result stays visible.
      state_d = StCollect;
      idx_d   = '0;
      err_d   = 1'b0;
    end else begin
      unique case (state_q)
        StCollect: begin
          if (in_valid) begin
            // First element seeds the maximum so a stale value from the last frame never wins.
            if (idx_q == '0) begin
              max_d  = $signed(in_data);
              best_d = '0;
            end else if ($signed(in_data) > max_q) begin
              max_d  = $signed(in_data);
              best_d = idx_q;
            end
            err_d = err_q | (in_last != is_last_pos);
            if (is_last_pos) begin
              idx_d       = '0;
              state_d     = StHold;
              predict_d   = best_d;
              frame_err_d = err_d;
              score_d     = max_d;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
        end
        StHold: begin
          if (out_ready) begin
            state_d = StCollect;
            err_d   = 1'b0;
          end
        end
        default: state_d = StCollect;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StCollect;
      idx_q       <= '0;
      max_q       <= '0;
      best_q      <= '0;
      err_q       <= 1'b0;
      predict_q   <= '1;
      frame_err_q <= 1'b0;
      score_q     <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      max_q       <= max_d;
      best_q      <= best_d;
      err_q       <= err_d;
      predict_q   <= predict_d;
      frame_err_q <= frame_err_d;
      score_q     <= score_d;
    end
  end

endmodule
